// File: rtl/peripheral_gpio_apb4_arbiter_if.sv
// peripheral_gpio_apb4_arbiter_if: upstream APB4 masters plus downstream GPIO slave bus.
// The master modport is the environment view; the slave modport is the arbiter view.
interface peripheral_gpio_apb4_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int PADDR_SIZE  = 10,
    parameter int PDATA_SIZE  = 8
);
    logic [NUM_MASTERS-1:0]            s_PSEL, s_PENABLE, s_PWRITE, s_PSTRB;
    logic [NUM_MASTERS*PADDR_SIZE-1:0] s_PADDR;
    logic [NUM_MASTERS*PDATA_SIZE-1:0] s_PWDATA;
    logic [PDATA_SIZE-1:0]             s_PRDATA;
    logic [NUM_MASTERS-1:0]            s_PREADY, s_PSLVERR;
    logic                              PSEL, PENABLE, PWRITE, PSTRB;
    logic [PADDR_SIZE-1:0]             PADDR;
    logic [PDATA_SIZE-1:0]             PWDATA, PRDATA;
    logic                              PREADY, PSLVERR;

    modport master (
        output s_PSEL, s_PENABLE, s_PWRITE, s_PSTRB, s_PADDR, s_PWDATA,
        input  s_PRDATA, s_PREADY, s_PSLVERR,
        input  PSEL, PENABLE, PWRITE, PSTRB, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  s_PSEL, s_PENABLE, s_PWRITE, s_PSTRB, s_PADDR, s_PWDATA,
        output s_PRDATA, s_PREADY, s_PSLVERR,
        output PSEL, PENABLE, PWRITE, PSTRB, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/peripheral_gpio_apb4_arbiter.sv
// peripheral_gpio_apb4_arbiter: round-robin sharing of the GPIO APB4 slave among several masters,
// with a watchdog that aborts ACCESS phases lasting TIMEOUT cycles.
module peripheral_gpio_apb4_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int PADDR_SIZE  = 10,
    parameter int PDATA_SIZE  = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    peripheral_gpio_apb4_arbiter_if.slave  bus,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
    output logic                           busy_o
);
    localparam int GW = $clog2(NUM_MASTERS);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d, ptr_q, ptr_d, pick;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] sel;
    logic                   done, abort, fin;
    logic                   unused_penable;

    assign unused_penable = ^bus.s_PENABLE;

    // Descending scan so the nearest requester after the pointer wins; the pointer itself is last.
    always_comb begin
        pick = ptr_q;
        for (int k = NUM_MASTERS; k >= 1; k--)
            if (bus.s_PSEL[(int'(ptr_q) + k) % NUM_MASTERS]) pick = GW'((int'(ptr_q) + k) % NUM_MASTERS);
    end

    assign done  = state_q == ACCESS && bus.PREADY;
    assign abort = state_q == ACCESS && !bus.PREADY && TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
    assign fin   = done || abort;

    always_comb begin
        state_d = state_q == IDLE  ? (|bus.s_PSEL ? SETUP : IDLE) :
                  state_q == SETUP ? ACCESS : (fin ? IDLE : ACCESS);
        grant_d = state_q == IDLE && |bus.s_PSEL ? pick : grant_q;
        ptr_d   = done ? grant_q : ptr_q;
        cnt_d   = state_q != ACCESS || fin ? '0 : cnt_q + 1'b1;
        sel     = '0;
        sel[grant_q] = fin;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PSEL      = state_q != IDLE;
    assign bus.PENABLE   = state_q == ACCESS;
    assign bus.PADDR     = bus.s_PADDR[grant_q*PADDR_SIZE +: PADDR_SIZE];
    assign bus.PWDATA    = bus.s_PWDATA[grant_q*PDATA_SIZE +: PDATA_SIZE];
    assign bus.PWRITE    = bus.s_PWRITE[grant_q];
    assign bus.PSTRB     = bus.s_PSTRB[grant_q];
    assign bus.s_PREADY  = sel;
    assign bus.s_PSLVERR = abort || bus.PSLVERR ? sel : '0;
    assign bus.s_PRDATA  = done ? bus.PRDATA : '0;
    assign grant_o       = grant_q;
    assign busy_o        = state_q != IDLE;
endmodule
